mc68k_bus_master: RTL and testbench

- 68000 bus initiator on the MB_CLK (7 MHz) side; lets on-card logic (DMA, SPI copy engine) become bus master on the A500 motherboard.
- Arbitrates via /BR, /BG and /BGACK, then runs asynchronous 68000 read/write cycles that motherboard responders complete with /DTACK or /BERR.
- Serves a simple level REQ/ACK interface on the local side.

---
 rtl/mc68k_bus_pkg.sv | 32 +++
 rtl/mc68k_sync2.sv | 27 ++
 rtl/mc68k_bus_master.sv | 190 +++++++++++++++++++
 tb/tb_mc68k_bus_master.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc68k_bus_pkg.sv
// mc68k_bus_pkg: shared types and constants for the A500 68000 bus master.
//   state_t      bus-master FSM states
//   SYNC_DEPTH   flops per asynchronous bus input
//   BE_*         REQ_BE encodings, {upper, lower}, active-high
package mc68k_bus_pkg;

  localparam int SYNC_DEPTH = 2;

  localparam logic [1:0] BE_NONE  = 2'b00;
  localparam logic [1:0] BE_LOWER = 2'b01;
  localparam logic [1:0] BE_UPPER = 2'b10;
  localparam logic [1:0] BE_WORD  = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ_BUS,
    ST_WAIT_FREE,
    ST_OWN,
    ST_S_ADDR,
    ST_S_STROBE,
    ST_S_WAIT,
    ST_S_DATA,
    ST_S_END,
    ST_RELEASE
  } state_t;

  // True while this card holds bus tenure (BGACK asserted, drivers enabled).
  function automatic logic in_tenure(input state_t s);
    return s inside {ST_OWN, ST_S_ADDR, ST_S_STROBE, ST_S_WAIT, ST_S_DATA, ST_S_END};
  endfunction

endpackage

// File: rtl/mc68k_sync2.sv
// mc68k_sync2: WIDTH-bit multi-flop synchroniser for asynchronous bus inputs.
// Resets to all-ones, since every bus input it carries is active-low.
//   clk    sampling clock
//   rst_n  asynchronous active-low reset
//   d      raw asynchronous inputs
//   q      synchronised outputs
module mc68k_sync2
  import mc68k_bus_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_DEPTH-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg <= '1;
    else        stg <= {stg[SYNC_DEPTH-2:0], d};
  end

  assign q = stg[SYNC_DEPTH-1];

endmodule

// File: rtl/mc68k_bus_master.sv
// mc68k_bus_master: 68000 bus initiator for the A500 motherboard (MB_CLK side).
// Gains the bus through /BR-/BG-/BGACK, runs asynchronous read/write cycles
// ended by /DTACK or /BERR, and serves a level REQ/ACK local interface.
// Optional build macro: MC68K_BM_TIMEOUT_EN adds an S_WAIT timeout that ends a
// hung cycle with REQ_ERR=1 after TIMEOUT_CYCLES.
// Ports:
//   MB_CLK, RESET                     clock, async active-low reset
//   REQ, REQ_WR, REQ_ADDR, REQ_BE,
//   REQ_WDATA                         local request (held until ACK)
//   REQ_ACK, REQ_ERR, REQ_RDATA       completion pulse, error flag, read data
//   BUSY                              not idle
//   MB_BR, MB_BGACK_OUT               bus request / grant ack (active low)
//   MB_BG, MB_BGACK_IN, MB_AS_IN      arbitration inputs (async, active low)
//   MB_DTACK, MB_BERR                 cycle terminators (async, active low)
//   ADDR_OUT, DATA_OUT, DATA_IN       bus address / data
//   AS_OUT, UDS_OUT, LDS_OUT, RW_OUT  bus strobes (active low), RW high=read
//   BUS_OE, DATA_OE                   external driver enables
module mc68k_bus_master
  import mc68k_bus_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
`ifdef MC68K_BM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        MB_CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        REQ_WR,
  input  logic [22:0] REQ_ADDR,
  input  logic [1:0]  REQ_BE,
  input  logic [15:0] REQ_WDATA,
  output logic        REQ_ACK,
  output logic        REQ_ERR,
  output logic [15:0] REQ_RDATA,
  output logic        BUSY,
  output logic        MB_BR,
  output logic        MB_BGACK_OUT,
  input  logic        MB_BG,
  input  logic        MB_BGACK_IN,
  input  logic        MB_AS_IN,
  input  logic        MB_DTACK,
  input  logic        MB_BERR,
  output logic [22:0] ADDR_OUT,
  output logic [15:0] DATA_OUT,
  input  logic [15:0] DATA_IN,
  output logic        AS_OUT,
  output logic        UDS_OUT,
  output logic        LDS_OUT,
  output logic        RW_OUT,
  output logic        BUS_OE,
  output logic        DATA_OE
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  hold_cnt, hold_n;
  logic        ack_n, err_n, load;
  logic [22:0] addr_q;
  logic [15:0] wdata_q, rdata_q;
  logic [1:0]  be_q;
  logic        wr_q;

  logic [4:0] sync_q;
  logic       bg_s, bgack_s, as_s, dtack_s, berr_s;

  mc68k_sync2 #(.WIDTH(5)) u_sync (
    .clk   (MB_CLK),
    .rst_n (RESET),
    .d     ({MB_BG, MB_BGACK_IN, MB_AS_IN, MB_DTACK, MB_BERR}),
    .q     (sync_q)
  );

  assign {bg_s, bgack_s, as_s, dtack_s, berr_s} = sync_q;

`ifdef MC68K_BM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET)                to_cnt <= '0;
    else if (state == ST_S_WAIT) to_cnt <= to_cnt + 8'd1;
    else                       to_cnt <= '0;
  end
`endif

  always_comb begin
    state_n = state;
    hold_n  = '0;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    load    = 1'b0;
    case (state)
      // REQ_ACK high blocks re-acceptance while the requester still shows the
      // request it is being acknowledged for.
      ST_IDLE:
        if (REQ && !REQ_ACK) begin
          if (REQ_BE == BE_NONE) begin ack_n = 1'b1; err_n = 1'b1; end
          else                     state_n = ST_REQ_BUS;
        end
      ST_REQ_BUS:
        if (!bg_s) state_n = ST_WAIT_FREE;
      ST_WAIT_FREE:
        if (bg_s)                            state_n = ST_REQ_BUS;
        else if (as_s && dtack_s && bgack_s) state_n = ST_OWN;
      ST_OWN:
        if (REQ) begin
          if (!REQ_ACK) begin
            if (REQ_BE == BE_NONE) begin ack_n = 1'b1; err_n = 1'b1; end
            else begin state_n = ST_S_ADDR; load = 1'b1; end
          end
        end else if (hold_cnt >= HOLD_LAST) begin
          state_n = ST_RELEASE;
        end else begin
          hold_n = hold_cnt + 4'd1;
        end
      ST_S_ADDR:   state_n = ST_S_STROBE;
      ST_S_STROBE: state_n = ST_S_WAIT;
      ST_S_WAIT:
        if (!berr_s) begin
          state_n = ST_S_END;
          err_n   = 1'b1;
        end else if (!dtack_s) begin
          state_n = ST_S_DATA;
        end
`ifdef MC68K_BM_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          state_n = ST_S_END;
          err_n   = 1'b1;
        end
`endif
      ST_S_DATA:   state_n = ST_S_END;
      ST_S_END:    state_n = ST_OWN;
      ST_RELEASE:  state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
    // ACK is registered so it coincides with the S_END cycle.
    if (state_n == ST_S_END) ack_n = 1'b1;
  end

  always_ff @(posedge MB_CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      REQ_ACK  <= 1'b0;
      REQ_ERR  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= BE_NONE;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      REQ_ACK  <= ack_n;
      REQ_ERR  <= err_n;
      if (load) begin
        addr_q <= REQ_ADDR;
        be_q   <= REQ_BE;
        wr_q   <= REQ_WR;
        if (REQ_WR) wdata_q <= REQ_WDATA;
      end
      // DTACK took two sync flops to reach us, so DATA_IN is long settled.
      if (state == ST_S_DATA && !wr_q) rdata_q <= DATA_IN;
    end
  end

  logic tenure, xfer, as_on, ds_on;

  assign tenure = in_tenure(state);
  assign xfer   = state inside {ST_S_ADDR, ST_S_STROBE, ST_S_WAIT, ST_S_DATA, ST_S_END};
  assign as_on  = state inside {ST_S_STROBE, ST_S_WAIT, ST_S_DATA};
  // Writes hold DS off for the AS cycle so data is set up before the strobe.
  assign ds_on  = wr_q ? (state inside {ST_S_WAIT, ST_S_DATA}) : as_on;

  assign MB_BR        = !(state inside {ST_REQ_BUS, ST_WAIT_FREE});
  assign MB_BGACK_OUT = !tenure;
  assign BUS_OE       = tenure;
  assign AS_OUT       = !as_on;
  assign UDS_OUT      = !(ds_on && be_q[1]);
  assign LDS_OUT      = !(ds_on && be_q[0]);
  assign RW_OUT       = !(xfer && wr_q);
  assign DATA_OE      = xfer && wr_q;
  assign ADDR_OUT     = addr_q;
  assign DATA_OUT     = wdata_q;
  assign REQ_RDATA    = rdata_q;
  assign BUSY         = (state != ST_IDLE);

endmodule

// File: tb/tb_mc68k_bus_master.sv
module tb_mc68k_bus_master;

  logic        MB_CLK = 1'b0;
  logic        RESET;
  logic        REQ, REQ_WR;
  logic [22:0] REQ_ADDR;
  logic [1:0]  REQ_BE;
  logic [15:0] REQ_WDATA;
  logic        REQ_ACK, REQ_ERR, BUSY;
  logic [15:0] REQ_RDATA;
  logic        MB_BR, MB_BGACK_OUT, MB_BG, MB_BGACK_IN, MB_AS_IN, MB_DTACK, MB_BERR;
  logic [22:0] ADDR_OUT;
  logic [15:0] DATA_OUT, DATA_IN;
  logic        AS_OUT, UDS_OUT, LDS_OUT, RW_OUT, BUS_OE, DATA_OE;

  always #5 MB_CLK = ~MB_CLK;

  mc68k_bus_master #(
    .HOLD_CYCLES(4)
`ifdef MC68K_BM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .MB_CLK(MB_CLK), .RESET(RESET),
    .REQ(REQ), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR), .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA),
    .REQ_ACK(REQ_ACK), .REQ_ERR(REQ_ERR), .REQ_RDATA(REQ_RDATA), .BUSY(BUSY),
    .MB_BR(MB_BR), .MB_BGACK_OUT(MB_BGACK_OUT), .MB_BG(MB_BG), .MB_BGACK_IN(MB_BGACK_IN),
    .MB_AS_IN(MB_AS_IN), .MB_DTACK(MB_DTACK), .MB_BERR(MB_BERR),
    .ADDR_OUT(ADDR_OUT), .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN),
    .AS_OUT(AS_OUT), .UDS_OUT(UDS_OUT), .LDS_OUT(LDS_OUT), .RW_OUT(RW_OUT),
    .BUS_OE(BUS_OE), .DATA_OE(DATA_OE)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---- motherboard models ----
  logic        arb_auto, bg_man, bg_r = 1'b1;
  int          br_cnt = 0;
  logic        dtack_en, berr_en;
  int          dtack_dly, berr_dly, as_cnt = 0;
  logic [15:0] rd_data;

  // CPU grants two cycles after BR falls, withdraws when BR rises.
  always @(posedge MB_CLK) begin
    if (MB_BR) begin br_cnt <= 0; bg_r <= 1'b1; end
    else begin br_cnt <= br_cnt + 1; if (br_cnt >= 1) bg_r <= 1'b0; end
  end
  assign MB_BG = arb_auto ? bg_r : bg_man;

  // Responder: terminates after the given number of AS-low cycles.
  always @(posedge MB_CLK) as_cnt <= AS_OUT ? 0 : as_cnt + 1;
  assign MB_DTACK = !(dtack_en && !AS_OUT && as_cnt >= dtack_dly);
  assign MB_BERR  = !(berr_en && !AS_OUT && as_cnt >= berr_dly);
  assign DATA_IN  = rd_data;

  // ---- bus timing tracker (samples the ending cycle at posedge) ----
  int   cyc = 0, as_start = 0, u_cnt = 0, l_cnt = 0, u_first = -1, l_first = -1;
  int   ack_cyc = 0, br_falls = 0, bgack_rise = 0, n_acks = 0;
  logic oe_at_ack = 0, rw_at_ack = 1, as_prev = 1, br_prev = 1, bgack_prev = 1;
  logic [15:0] dout_at_ack = 0;

  always @(posedge MB_CLK) begin
    if (!AS_OUT && as_prev) begin
      as_start = cyc; u_cnt = 0; l_cnt = 0; u_first = -1; l_first = -1;
    end
    if (!UDS_OUT) begin if (u_first < 0) u_first = cyc; u_cnt++; end
    if (!LDS_OUT) begin if (l_first < 0) l_first = cyc; l_cnt++; end
    if (REQ_ACK) begin
      ack_cyc = cyc; oe_at_ack = DATA_OE; rw_at_ack = RW_OUT; dout_at_ack = DATA_OUT; n_acks++;
    end
    if (!MB_BR && br_prev) br_falls++;
    if (MB_BGACK_OUT && !bgack_prev) bgack_rise = cyc;
    as_prev = AS_OUT; br_prev = MB_BR; bgack_prev = MB_BGACK_OUT;
    cyc++;
  end

  // ---- scoreboard ----
  typedef struct { logic err; logic [15:0] rdata; } exp_t;
  exp_t exp_q[$];

  always @(negedge MB_CLK) begin
    if (RESET && REQ_ACK) begin
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 32'(REQ_ACK), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_err", 32'(REQ_ERR), 32'(e.err));
        chk("sb_rdata", 32'(REQ_RDATA), 32'(e.rdata));
      end
    end
  end

  task automatic wait_ack();
    @(negedge MB_CLK);
    for (int i = 0; i < 400 && !REQ_ACK; i++) @(negedge MB_CLK);
    chk("ack_seen", 32'(REQ_ACK), 32'd1);
  endtask

  task automatic present(input logic wr, input logic [22:0] a, input logic [1:0] be,
                         input logic [15:0] wd);
    REQ_WR = wr; REQ_ADDR = a; REQ_BE = be; REQ_WDATA = wd; REQ = 1'b1;
  endtask

  // Returns at the negedge of the ACK cycle, REQ still asserted.
  task automatic do_req(input logic wr, input logic [22:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input logic eerr, input logic [15:0] erd);
    exp_t e;
    e.err = eerr; e.rdata = erd;
    exp_q.push_back(e);
    present(wr, a, be, wd);
    wait_ack();
  endtask

  task automatic idle_wait();
    repeat (12) @(negedge MB_CLK);
    chk("idle_busy", 32'(BUSY), 32'd0);
  endtask

  localparam logic [10:0] RST_VEC = 11'b111111_00000;

  initial begin
    int bad, n0;
    RESET = 1'b0; REQ = 1'b0; REQ_WR = 1'b0; REQ_ADDR = '0; REQ_BE = '0; REQ_WDATA = '0;
    MB_BGACK_IN = 1'b1; MB_AS_IN = 1'b1; arb_auto = 1'b1; bg_man = 1'b1;
    dtack_en = 1'b1; dtack_dly = 0; berr_en = 1'b0; berr_dly = 0; rd_data = 16'hBEEF;
    repeat (3) @(negedge MB_CLK);
    chk("rst_ctrl", 32'({MB_BR, MB_BGACK_OUT, AS_OUT, UDS_OUT, LDS_OUT, RW_OUT,
                         BUS_OE, DATA_OE, REQ_ACK, REQ_ERR, BUSY}), 32'(RST_VEC));
    chk("rst_data", {REQ_RDATA, DATA_OUT}, 32'd0);
    chk("rst_addr", 32'(ADDR_OUT), 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge MB_CLK);

    // BE=00 from IDLE: immediate error ACK, no bus activity
    br_falls = 0;
    do_req(1'b0, 23'h000010, 2'b00, 16'h0, 1'b1, 16'h0000);
    REQ = 1'b0;
    @(negedge MB_CLK);
    chk("be0_busy", 32'(BUSY), 32'd0);
    chk("be0_no_br", 32'(br_falls), 32'd0);

    // Read, zero waits
    do_req(1'b0, 23'h060000, 2'b11, 16'h0, 1'b0, 16'hBEEF);
    REQ = 1'b0;
    @(negedge MB_CLK);
    chk("rd_latency", 32'(ack_cyc - as_start), 32'd4);
    chk("rd_uds_first", 32'(u_first - as_start), 32'd0);
    chk("rd_uds_cycles", 32'(u_cnt), 32'd4);
    chk("rd_lds_cycles", 32'(l_cnt), 32'd4);
    chk("rd_addr", 32'(ADDR_OUT), 32'h060000);
    idle_wait();

    // Write, lower byte, DTACK 6 cycles after AS
    dtack_dly = 6;
    do_req(1'b1, 23'h012345, 2'b01, 16'h00A5, 1'b0, 16'hBEEF);
    REQ = 1'b0;
    @(negedge MB_CLK);
    chk("wr_latency", 32'(ack_cyc - as_start), 32'd10);
    chk("wr_uds_idle", 32'(u_cnt), 32'd0);
    chk("wr_lds_delay", 32'(l_first - as_start), 32'd1);
    chk("wr_lds_cycles", 32'(l_cnt), 32'd9);
    chk("wr_oe_at_end", 32'(oe_at_ack), 32'd1);
    chk("wr_rw_at_end", 32'(rw_at_ack), 32'd0);
    chk("wr_dout", 32'(dout_at_ack), 32'h00A5);
    chk("wr_oe_after", 32'({DATA_OE, RW_OUT}), 32'b01);
    dtack_dly = 0;
    idle_wait();

    // Back-to-back: one tenure, release HOLD_CYCLES+1 after last ACK
    br_falls = 0; rd_data = 16'h1234;
    do_req(1'b0, 23'h000100, 2'b11, 16'h0, 1'b0, 16'h1234);
    rd_data = 16'h4321;
    do_req(1'b1, 23'h000101, 2'b10, 16'h5A00, 1'b0, 16'h1234);
    do_req(1'b0, 23'h000102, 2'b11, 16'h0, 1'b0, 16'h4321);
    REQ = 1'b0;
    idle_wait();
    chk("b2b_one_br", 32'(br_falls), 32'd1);
    chk("b2b_release", 32'(bgack_rise - ack_cyc), 32'd5);

    // Arbitration contention: another master holds BGACK
    arb_auto = 1'b0; bg_man = 1'b1; MB_BGACK_IN = 1'b0; rd_data = 16'h0F0F;
    begin exp_t e; e.err = 1'b0; e.rdata = 16'h0F0F; exp_q.push_back(e); end
    present(1'b0, 23'h000200, 2'b11, 16'h0);
    for (int i = 0; i < 20 && MB_BR; i++) @(negedge MB_CLK);
    chk("arb_br_low", 32'(MB_BR), 32'd0);
    bg_man = 1'b0;
    repeat (4) @(negedge MB_CLK);
    bad = 0;
    repeat (10) begin
      @(negedge MB_CLK);
      if (BUS_OE || MB_BR || !MB_BGACK_OUT) bad++;
    end
    chk("arb_wait_free", 32'(bad), 32'd0);
    bg_man = 1'b1;
    repeat (4) @(negedge MB_CLK);
    chk("arb_back_br", 32'({MB_BR, BUSY}), 32'b01);
    MB_BGACK_IN = 1'b1;
    repeat (4) @(negedge MB_CLK);
    chk("arb_no_own_wo_bg", 32'(BUS_OE), 32'd0);
    arb_auto = 1'b1;
    wait_ack();
    REQ = 1'b0;
    @(negedge MB_CLK);

    // BERR: error ACK, RDATA unchanged
    dtack_en = 1'b0; berr_en = 1'b1; berr_dly = 2; rd_data = 16'hDEAD;
    do_req(1'b0, 23'h000300, 2'b11, 16'h0, 1'b1, 16'h0F0F);
    REQ = 1'b0;
    berr_en = 1'b0;
    @(negedge MB_CLK);
    chk("berr_latency", 32'(ack_cyc - as_start), 32'd5);

    // Reset in the middle of S_WAIT
    present(1'b0, 23'h000304, 2'b11, 16'h0);
    for (int i = 0; i < 20 && AS_OUT; i++) @(negedge MB_CLK);
    repeat (3) @(negedge MB_CLK);
    chk("mid_in_cycle", 32'(AS_OUT), 32'd0);
    #2 RESET = 1'b0;
    #1;
    chk("mid_rst_ctrl", 32'({MB_BR, MB_BGACK_OUT, AS_OUT, UDS_OUT, LDS_OUT, RW_OUT,
                             BUS_OE, DATA_OE, REQ_ACK, REQ_ERR, BUSY}), 32'(RST_VEC));
    chk("mid_rst_rdata", 32'(REQ_RDATA), 32'd0);
    REQ = 1'b0;
    @(negedge MB_CLK);
    RESET = 1'b1;
    repeat (2) @(negedge MB_CLK);

`ifdef MC68K_BM_TIMEOUT_EN
    do_req(1'b0, 23'h000400, 2'b11, 16'h0, 1'b1, 16'h0000);
    REQ = 1'b0;
    @(negedge MB_CLK);
    chk("to_latency", 32'(ack_cyc - as_start), 32'd17);
`else
    n0 = n_acks;
    present(1'b0, 23'h000400, 2'b11, 16'h0);
    repeat (1000) @(negedge MB_CLK);
    chk("no_to_acks", 32'(n_acks - n0), 32'd0);
    chk("no_to_as_held", 32'(AS_OUT), 32'd0);
    RESET = 1'b0; REQ = 1'b0;
    @(negedge MB_CLK);
    RESET = 1'b1;
`endif
    dtack_en = 1'b1;
    repeat (5) @(negedge MB_CLK);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
